// File: rtl/tight_acc_mem_responder.sv
// Memory-side responder: accepts line requests, returns store data in order
// after a fixed latency, with a preloadable backing store.
module tight_acc_mem_responder #(
    parameter int ADDR_W    = 40,
    parameter int DATA_W    = 512,
    parameter int LAT       = 4,
    parameter int DEPTH     = 8,
    parameter int MEM_LINES = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_req_val,
    output logic                         mem_req_rdy,
    input  logic [5:0]                   mem_req_transid,
    input  logic [ADDR_W-1:0]            mem_req_addr,
    output logic                         mem_resp_val,
    output logic [5:0]                   mem_resp_transid,
    output logic [DATA_W-1:0]            mem_resp_data,
    input  logic                         ld_val,
    input  logic [$clog2(MEM_LINES)-1:0] ld_idx,
    input  logic [DATA_W-1:0]            ld_data,
    output logic [$clog2(DEPTH):0]       outstanding
);
    localparam int PW = $clog2(DEPTH);
    localparam int IW = $clog2(MEM_LINES);
    localparam int OW = PW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]     outstanding_q, outstanding_d;
    logic              resp_val_q, resp_val_d;
    logic [5:0]        resp_tid_q, resp_tid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;

    logic [DEPTH-1:0]         vld_all;
    logic [DEPTH-1:0][5:0]    tid_all;
    logic [DEPTH-1:0][IW-1:0] idx_all;
    logic [DEPTH-1:0][3:0]    cnt_all;

    logic accept;
    logic pop;
    logic unused_addr_bits;

    logic [DATA_W-1:0] store_q [MEM_LINES];

    // Ready is deliberately not bypassed by a same-cycle pop.
    assign mem_req_rdy = !rst && (outstanding_q < OW'(DEPTH));
    assign accept      = mem_req_val && mem_req_rdy;
    // Equal latency for every entry means the head always expires first.
    assign pop         = vld_all[rd_ptr_q] && (cnt_all[rd_ptr_q] == 4'd0);

    assign unused_addr_bits = ^{mem_req_addr[ADDR_W-1:6+IW], mem_req_addr[5:0]};

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
        logic          vld_q, vld_d;
        logic [5:0]    tid_q, tid_d;
        logic [IW-1:0] idx_q, idx_d;
        logic [3:0]    cnt_q, cnt_d;
        logic          hit_wr, hit_rd;

        assign hit_wr = accept && (wr_ptr_q == PW'(gi));
        assign hit_rd = pop && (rd_ptr_q == PW'(gi));

        always_comb begin
            vld_d = vld_q;
            tid_d = tid_q;
            idx_d = idx_q;
            cnt_d = cnt_q;
            if (vld_q && cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end
            if (hit_rd) begin
                vld_d = 1'b0;
            end
            if (hit_wr) begin
                vld_d = 1'b1;
                tid_d = mem_req_transid;
                idx_d = mem_req_addr[6 +: IW];
                cnt_d = 4'(LAT - 1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                tid_q <= '0;
                idx_q <= '0;
                cnt_q <= '0;
            end else begin
                vld_q <= vld_d;
                tid_q <= tid_d;
                idx_q <= idx_d;
                cnt_q <= cnt_d;
            end
        end

        assign vld_all[gi] = vld_q;
        assign tid_all[gi] = tid_q;
        assign idx_all[gi] = idx_q;
        assign cnt_all[gi] = cnt_q;
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q + PW'(accept);
        rd_ptr_d      = rd_ptr_q + PW'(pop);
        outstanding_d = outstanding_q;
        if (accept && !pop) begin
            outstanding_d = outstanding_q + OW'(1);
        end else if (!accept && pop) begin
            outstanding_d = outstanding_q - OW'(1);
        end
        resp_val_d  = pop;
        resp_tid_d  = '0;
        resp_data_d = '0;
        // The store is read here, before any same-edge load lands.
        if (pop) begin
            resp_tid_d  = tid_all[rd_ptr_q];
            resp_data_d = store_q[idx_all[rd_ptr_q]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            resp_val_q    <= 1'b0;
            resp_tid_q    <= '0;
            resp_data_q   <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            outstanding_q <= outstanding_d;
            resp_val_q    <= resp_val_d;
            resp_tid_q    <= resp_tid_d;
            resp_data_q   <= resp_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_val) begin
            store_q[ld_idx] <= ld_data;
        end
    end

    assign mem_resp_val     = resp_val_q;
    assign mem_resp_transid = resp_tid_q;
    assign mem_resp_data    = resp_data_q;
    assign outstanding      = outstanding_q;
endmodule

// File: tb/tb_tight_acc_mem_responder.sv
// Bench for tight_acc_mem_responder: three instances (LAT 4/1/12) share stimulus
// and are checked against a queue-based timing model plus directed expectations.
module tb_tight_acc_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         req_val;
    logic [5:0]   req_tid;
    logic [39:0]  req_addr;
    logic         ld_val;
    logic [5:0]   ld_idx;
    logic [511:0] ld_data;

    logic rdy_a, rdy_b, rdy_c, rv_a, rv_b, rv_c;
    logic [5:0] rt_a, rt_b, rt_c;
    logic [511:0] rd_a, rd_b, rd_c;
    logic [3:0] out_a, out_c;
    logic [2:0] out_b;

    logic         rdy [3];
    logic         rv [3];
    logic [5:0]   rt [3];
    logic [511:0] rdat [3];
    logic [3:0]   outs [3];

    int tests_run = 0;
    int tests_failed = 0;

    tight_acc_mem_responder #(.LAT(4), .DEPTH(8)) u_a (
        .clk(clk), .rst(rst), .mem_req_val(req_val), .mem_req_rdy(rdy_a),
        .mem_req_transid(req_tid), .mem_req_addr(req_addr), .mem_resp_val(rv_a),
        .mem_resp_transid(rt_a), .mem_resp_data(rd_a), .ld_val(ld_val),
        .ld_idx(ld_idx), .ld_data(ld_data), .outstanding(out_a));
    tight_acc_mem_responder #(.LAT(1), .DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .mem_req_val(req_val), .mem_req_rdy(rdy_b),
        .mem_req_transid(req_tid), .mem_req_addr(req_addr), .mem_resp_val(rv_b),
        .mem_resp_transid(rt_b), .mem_resp_data(rd_b), .ld_val(ld_val),
        .ld_idx(ld_idx), .ld_data(ld_data), .outstanding(out_b));
    tight_acc_mem_responder #(.LAT(12), .DEPTH(8)) u_c (
        .clk(clk), .rst(rst), .mem_req_val(req_val), .mem_req_rdy(rdy_c),
        .mem_req_transid(req_tid), .mem_req_addr(req_addr), .mem_resp_val(rv_c),
        .mem_resp_transid(rt_c), .mem_resp_data(rd_c), .ld_val(ld_val),
        .ld_idx(ld_idx), .ld_data(ld_data), .outstanding(out_c));

    always_comb begin
        rdy[0] = rdy_a;  rdy[1] = rdy_b;  rdy[2] = rdy_c;
        rv[0] = rv_a;    rv[1] = rv_b;    rv[2] = rv_c;
        rt[0] = rt_a;    rt[1] = rt_b;    rt[2] = rt_c;
        rdat[0] = rd_a;  rdat[1] = rd_b;  rdat[2] = rd_c;
        outs[0] = out_a; outs[1] = {1'b0, out_b}; outs[2] = out_c;
    end

    // Reference model: each accepted request is due at accept_edge + LAT.
    typedef struct {
        logic [5:0] tid;
        int         idx;
        longint     due;
    } ent_t;

    ent_t         mq [3][$];
    logic [511:0] store_m [64];
    logic         m_val [3];
    logic [5:0]   m_tid [3];
    logic [511:0] m_data [3];
    logic [3:0]   m_out [3];
    longint       n_edge = 0;
    ent_t         me;
    bit           m_pre;

    function automatic int lat_of(int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : 12;
    endfunction

    function automatic int dep_of(int i);
        return (i == 1) ? 4 : 8;
    endfunction

    function automatic logic exp_rdy(int i);
        return !rst && (mq[i].size() < dep_of(i));
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] v;
        for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mq[i].delete();
                m_val[i] = 1'b0; m_tid[i] = '0; m_data[i] = '0; m_out[i] = '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_pre = mq[i].size() < dep_of(i);
                m_val[i] = 1'b0; m_tid[i] = '0; m_data[i] = '0;
                if (mq[i].size() > 0 && mq[i][0].due == n_edge) begin
                    me = mq[i].pop_front();
                    m_val[i] = 1'b1; m_tid[i] = me.tid; m_data[i] = store_m[me.idx];
                end
                if (req_val && m_pre) begin
                    me.tid = req_tid; me.idx = int'(req_addr[11:6]);
                    me.due = n_edge + lat_of(i);
                    mq[i].push_back(me);
                end
                m_out[i] = 4'(mq[i].size());
            end
            if (ld_val) store_m[ld_idx] = ld_data;
            n_edge++;
        end
    end

    task automatic drive_idle();
        req_val = 1'b0; req_tid = '0; req_addr = '0;
        ld_val = 1'b0; ld_idx = '0; ld_data = '0;
    endtask

    task automatic drain();
        drive_idle();
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({rdy[i], rv[i], rt[i], rdat[i], outs[i]} !== {1'b0, 1'b0, 6'd0, 512'd0, 4'd0}) begin
                tests_failed++;
                $display("FAIL reset_state inst%0d: got rdy=%b val=%b tid=%h out=%0d, want all zero",
                         i, rdy[i], rv[i], rt[i], outs[i]);
            end
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (rdy[i] !== 1'b1) begin
                tests_failed++;
                $display("FAIL rdy_after_reset inst%0d: got %b want 1", i, rdy[i]);
            end
        end
        @(negedge clk);
        for (int l = 0; l < 64; l++) begin
            ld_val = 1'b1; ld_idx = 6'(l); ld_data = rand_line();
            @(negedge clk);
        end
        drive_idle();
    endtask

    task automatic test_single();
        logic ev;
        ld_val = 1'b1; ld_idx = 6'd3; ld_data = {64{8'hA5}};
        @(negedge clk);
        drive_idle();
        req_val = 1'b1; req_tid = 6'h11; req_addr = 40'hC0;
        @(negedge clk);
        drive_idle();
        for (int k = 0; k < 8; k++) begin
            ev = (k == 4);
            tests_run++;
            if ({rv[0], rt[0], rdat[0], outs[0]} !==
                {ev, ev ? 6'h11 : 6'h00, ev ? {64{8'hA5}} : 512'd0, (k < 4) ? 4'd1 : 4'd0}) begin
                tests_failed++;
                $display("FAIL single_req k=%0d: got val=%b tid=%h out=%0d data=%h, want val=%b",
                         k, rv[0], rt[0], outs[0], rdat[0], ev);
            end
            @(negedge clk);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic ev;
        logic [5:0] et;
        for (int k = 0; k < 20; k++) begin
            if (k < 8) begin
                req_val = 1'b1; req_tid = 6'(k); req_addr = 40'(k * 64);
            end else begin
                drive_idle();
            end
            @(negedge clk);
            ev = (k >= 4) && (k < 12);
            et = ev ? 6'(k - 4) : 6'd0;
            tests_run++;
            if ({rv[0], rt[0]} !== {ev, et}) begin
                tests_failed++;
                $display("FAIL b2b_tag k=%0d: got val=%b tid=%h, want val=%b tid=%h", k, rv[0], rt[0], ev, et);
            end
            tests_run++;
            if ({rv[0], rt[0], rdat[0], outs[0], rdy[0]} !== {m_val[0], m_tid[0], m_data[0], m_out[0], exp_rdy(0)}) begin
                tests_failed++;
                $display("FAIL b2b_model k=%0d: got data=%h out=%0d, want data=%h out=%0d",
                         k, rdat[0], outs[0], m_data[0], m_out[0]);
            end
        end
        drain();
    endtask

    task automatic test_full();
        int acc = 0;
        int resp = 0;
        int acc_at_fall = -1;
        int cyc = 0;
        bit seen_low = 0;
        logic [5:0] tids [$];
        while ((acc < 12 || resp < 12) && cyc < 100) begin
            if (acc < 12) begin
                req_val = 1'b1; req_tid = 6'($urandom);
                req_addr = {28'h0, 6'($urandom), 6'($urandom)};
                if (mq[2].size() < 8) begin
                    tids.push_back(req_tid);
                    acc++;
                end
            end else begin
                drive_idle();
            end
            @(negedge clk);
            cyc++;
            if (rv[2] === 1'b1) begin
                resp++;
                tests_run++;
                if (tids.size() == 0 || rt[2] !== tids[0]) begin
                    tests_failed++;
                    $display("FAIL full_order resp%0d: got tid=%h want %h", resp, rt[2],
                             (tids.size() > 0) ? tids[0] : 6'h00);
                end
                if (tids.size() > 0) void'(tids.pop_front());
            end
            if (!seen_low && rdy[2] === 1'b0) begin
                seen_low = 1;
                acc_at_fall = acc;
            end
            tests_run++;
            if (!(outs[2] <= 4'd8) || {rv[2], rt[2], rdat[2], outs[2], rdy[2]} !==
                {m_val[2], m_tid[2], m_data[2], m_out[2], exp_rdy(2)}) begin
                tests_failed++;
                $display("FAIL full_model cyc=%0d: got out=%0d rdy=%b val=%b, want out=%0d rdy=%b val=%b",
                         cyc, outs[2], rdy[2], rv[2], m_out[2], exp_rdy(2), m_val[2]);
            end
        end
        tests_run++;
        if (acc_at_fall != 8) begin
            tests_failed++;
            $display("FAIL full_rdy_fall: ready fell after %0d accepts, want 8", acc_at_fall);
        end
        tests_run++;
        if (resp != 12) begin
            tests_failed++;
            $display("FAIL full_resp_count: got %0d responses want 12", resp);
        end
        drain();
    endtask

    task automatic test_load_vis(input int wr_k, input logic [511:0] expd, input string name);
        for (int k = 0; k < 8; k++) begin
            drive_idle();
            if (k == 0) begin
                ld_val = 1'b1; ld_idx = 6'd5; ld_data = 512'd1;
            end
            if (k == 1) begin
                req_val = 1'b1; req_tid = 6'h05; req_addr = 40'h140;
            end
            if (k == wr_k) begin
                ld_val = 1'b1; ld_idx = 6'd5; ld_data = 512'd2;
            end
            @(negedge clk);
            if (k == 5) begin
                tests_run++;
                if (rv[0] !== 1'b1 || rdat[0] !== expd) begin
                    tests_failed++;
                    $display("FAIL %s: got val=%b data=%0h, want val=1 data=%0h", name, rv[0], rdat[0], expd);
                end
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            req_val = 1'b1; req_tid = 6'(32 + k); req_addr = {28'h0, 6'($urandom), 6'($urandom)};
            @(negedge clk);
        end
        drive_idle();
        rst = 1'b1;
        #1;
        tests_run++;
        if ({outs[0], rv[0], rdy[0]} !== {4'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_mid_assert: got out=%0d val=%b rdy=%b, want 0 0 0", outs[0], rv[0], rdy[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            tests_run++;
            if ({rv[0], rv[2], outs[0], outs[2], rdy[0], rdy[2]} !== {1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1}) begin
                tests_failed++;
                $display("FAIL reset_mid_after k=%0d: got val=%b/%b out=%0d/%0d rdy=%b/%b, want 0/0 0/0 1/1",
                         k, rv[0], rv[2], outs[0], outs[2], rdy[0], rdy[2]);
            end
        end
    endtask

    task automatic test_lat1_dup();
        logic ev;
        for (int k = 0; k < 6; k++) begin
            if (k < 2) begin
                req_val = 1'b1; req_tid = 6'h3F; req_addr = {28'h0, 6'($urandom), 6'($urandom)};
            end else begin
                drive_idle();
            end
            @(negedge clk);
            ev = (k == 1) || (k == 2);
            tests_run++;
            if ({rv[1], rt[1]} !== {ev, ev ? 6'h3F : 6'h00}) begin
                tests_failed++;
                $display("FAIL lat1_dup k=%0d: got val=%b tid=%h, want val=%b", k, rv[1], rt[1], ev);
            end
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req_val = ($urandom_range(9) < 6);
            req_tid = 6'($urandom);
            req_addr = {8'($urandom), 32'($urandom)};
            ld_val = ($urandom_range(3) == 0);
            ld_idx = 6'($urandom);
            ld_data = rand_line();
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if ({rv[i], rt[i], rdat[i], outs[i], rdy[i]} !== {m_val[i], m_tid[i], m_data[i], m_out[i], exp_rdy(i)}) begin
                    tests_failed++;
                    $display("FAIL random c=%0d inst%0d: got val=%b tid=%h out=%0d rdy=%b, want val=%b tid=%h out=%0d rdy=%b",
                             c, i, rv[i], rt[i], outs[i], rdy[i], m_val[i], m_tid[i], m_out[i], exp_rdy(i));
                end
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_load_vis(3, 512'd2, "load_before_resp");
        test_load_vis(5, 512'd1, "load_on_resp_edge");
        test_reset_mid();
        test_lat1_dup();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
